// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, controller
// states and the default busy latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Multi-cycle operations are the ones that occupy the unit and stall MD reads.
  function automatic logic is_long_op(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the full HI/LO result for the
// selected operation and a write enable that is dropped on divide by zero.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        we_o
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        div_zero;
  logic [31:0] udivisor;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] sdivisor;
  logic [31:0] mquot;
  logic [31:0] mrem;
  logic [31:0] squot;
  logic [31:0] srem;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign sprod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign uprod = {32'd0, a_i} * {32'd0, b_i};

  assign div_zero = (b_i == 32'd0);
  assign udivisor = div_zero ? 32'd1 : b_i;
  assign uquot    = a_i / udivisor;
  assign urem     = a_i % udivisor;

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0.
  assign mag_a    = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign mag_b    = b_i[31] ? (~b_i + 32'd1) : b_i;
  assign sdivisor = div_zero ? 32'd1 : mag_b;
  assign mquot    = mag_a / sdivisor;
  assign mrem     = mag_a % sdivisor;
  assign squot    = (a_i[31] ^ b_i[31]) ? (~mquot + 32'd1) : mquot;
  assign srem     = a_i[31] ? (~mrem + 32'd1) : mrem;

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    we_o = 1'b0;
    case (md_op_i)
      MD_MULT: begin
        hi_o = sprod[63:32];
        lo_o = sprod[31:0];
        we_o = 1'b1;
      end
      MD_MULTU: begin
        hi_o = uprod[63:32];
        lo_o = uprod[31:0];
        we_o = 1'b1;
      end
      MD_DIV: begin
        hi_o = srem;
        lo_o = squot;
        we_o = !div_zero;
      end
      MD_DIVU: begin
        hi_o = urem;
        lo_o = uquot;
        we_o = !div_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, holds the computed result for the
// modelled latency and requests a stall for D-stage MD instructions meanwhile.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_instr_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_we;
  logic             long_op;

  mdu_arith u_arith (
    .md_op_i (md_op),
    .a_i     (src_a),
    .b_i     (src_b),
    .hi_o    (arith_hi),
    .lo_o    (arith_lo),
    .we_o    (arith_we)
  );

  assign long_op = is_long_op(md_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (long_op) begin
            pend_hi_d = arith_hi;
            pend_lo_d = arith_lo;
            pend_we_d = arith_we;
            cnt_d     = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                        CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d   = BUSY;
          end else if (md_op == MD_MTHI) begin
            hi_d = src_a;
          end else if (md_op == MD_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      BUSY: begin
        // A start arriving here is a protocol violation and is deliberately ignored.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == BUSY);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = md_instr_d & (busy | (start & long_op));

  startWhileBusy: assert property (@(posedge clk) disable iff (reset) !(start && busy))
    else $error("mdu_ctrl: start asserted while busy");

endmodule
